// File: rtl/bram_rmw_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bram_rmw_scheduler
//  Description : Owns both ports of one dual-port feature-map BRAM and
//                serialises two requesters onto it through a 4-stage pipeline.
//                  U : read-modify-write updates, mem[addr] += delta
//                  R : reads, optionally clear-on-read (writes 0 back)
//                Port A only reads, port B only writes; one op per cycle.
//  Ports       : clk, rst                        clock, sync active-high reset
//                upd_valid/ready/addr/delta      update request channel
//                rd_valid/ready/addr/clear       read request channel
//                rd_resp_valid/rd_resp_data      read response (pre-clear word)
//                busy                            any pipeline stage occupied
//                bram_*_a / bram_*_b             BRAM port A (read), B (write)
//  Revision    : 1.0  initial release
// ============================================================================
module bram_rmw_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [ADDR_WIDTH-1:0] upd_addr,
    input  logic [DATA_WIDTH-1:0] upd_delta,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_clear,
    output logic                  rd_resp_valid,
    output logic [DATA_WIDTH-1:0] rd_resp_data,
    output logic                  busy,
    output logic                  bram_en_a,
    output logic                  bram_we_a,
    output logic [ADDR_WIDTH-1:0] bram_addr_a,
    output logic [DATA_WIDTH-1:0] bram_data_in_a,
    input  logic [DATA_WIDTH-1:0] bram_data_out_a,
    output logic                  bram_en_b,
    output logic                  bram_we_b,
    output logic [ADDR_WIDTH-1:0] bram_addr_b,
    output logic [DATA_WIDTH-1:0] bram_data_in_b,
    input  logic [DATA_WIDTH-1:0] bram_data_out_b
);

    localparam logic [DATA_WIDTH-1:0] c_max = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] c_min = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Stage S1: BRAM read issued. Stage S2: read data returns, new value built.
    logic                  r_s1_valid, r_s1_wr, r_s1_upd;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic [DATA_WIDTH-1:0] r_s1_delta;
    logic                  r_s2_valid, r_s2_wr, r_s2_upd;
    logic [ADDR_WIDTH-1:0] r_s2_addr;
    logic [DATA_WIDTH-1:0] r_s2_delta;
    // Stage S3: registered write strobe and response.
    logic                  r_s3_valid;
    logic                  r_we_b;
    logic [ADDR_WIDTH-1:0] r_addr_b;
    logic [DATA_WIDTH-1:0] r_data_b;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_data;
    // Round-robin pointer: 1 when R was granted last, 0 when U was.
    logic                  r_last_r;

    logic w_upd_haz, w_rd_haz, w_upd_elig, w_rd_elig;
    logic w_grant_u, w_grant_r, w_acc_u, w_acc_r, w_acc;
    logic [DATA_WIDTH-1:0] w_upd_new, w_new;
    logic w_unused_ok;

    // Only writing ops in S1/S2 can race a new read; an S3 write commits
    // at the end of this cycle, before a newly accepted op reads in S1.
    assign w_upd_haz = (r_s1_wr && (r_s1_addr == upd_addr)) ||
                       (r_s2_wr && (r_s2_addr == upd_addr));
    assign w_rd_haz  = (r_s1_wr && (r_s1_addr == rd_addr)) ||
                       (r_s2_wr && (r_s2_addr == rd_addr));

    assign w_upd_elig = upd_valid && !w_upd_haz;
    assign w_rd_elig  = rd_valid  && !w_rd_haz;

    // On contention grant whichever requester was not served last.
    assign w_grant_u = w_upd_elig && (!w_rd_elig ||  r_last_r);
    assign w_grant_r = w_rd_elig  && (!w_upd_elig || !r_last_r);

    // An accept in a reset cycle would be dropped, so no handshake is offered.
    assign upd_ready = w_grant_u && !rst;
    assign rd_ready  = w_grant_r && !rst;

    assign w_acc_u = upd_valid && upd_ready;
    assign w_acc_r = rd_valid  && rd_ready;
    assign w_acc   = w_acc_u || w_acc_r;

    generate
        if (SATURATE != 0) begin : g_sat
            logic [DATA_WIDTH:0] w_sum;
            assign w_sum = {bram_data_out_a[DATA_WIDTH-1], bram_data_out_a} +
                           {r_s2_delta[DATA_WIDTH-1], r_s2_delta};
            // Overflow shows as the two top bits of the extended sum differing.
            always_comb begin
                w_upd_new = w_sum[DATA_WIDTH-1:0];
                if (w_sum[DATA_WIDTH] != w_sum[DATA_WIDTH-1]) begin
                    w_upd_new = w_sum[DATA_WIDTH] ? c_min : c_max;
                end
            end
        end else begin : g_wrap
            assign w_upd_new = bram_data_out_a + r_s2_delta;
        end
    endgenerate

    assign w_new = r_s2_upd ? w_upd_new : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_wr      <= 1'b0;
            r_s1_upd     <= 1'b0;
            r_s1_addr    <= '0;
            r_s1_delta   <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_wr      <= 1'b0;
            r_s2_upd     <= 1'b0;
            r_s2_addr    <= '0;
            r_s2_delta   <= '0;
            r_s3_valid   <= 1'b0;
            r_we_b       <= 1'b0;
            r_addr_b     <= '0;
            r_data_b     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_last_r     <= 1'b0;
        end else begin
            r_s1_valid <= w_acc;
            r_s1_wr    <= w_acc_u || (w_acc_r && rd_clear);
            if (w_acc) begin
                r_s1_upd   <= w_acc_u;
                r_s1_addr  <= w_acc_u ? upd_addr : rd_addr;
                r_s1_delta <= upd_delta;
            end

            r_s2_valid <= r_s1_valid;
            r_s2_wr    <= r_s1_wr;
            if (r_s1_valid) begin
                r_s2_upd   <= r_s1_upd;
                r_s2_addr  <= r_s1_addr;
                r_s2_delta <= r_s1_delta;
            end

            r_s3_valid   <= r_s2_valid;
            r_we_b       <= r_s2_valid && r_s2_wr;
            r_resp_valid <= r_s2_valid && !r_s2_upd;
            if (r_s2_valid && r_s2_wr) begin
                r_addr_b <= r_s2_addr;
                r_data_b <= w_new;
            end
            if (r_s2_valid && !r_s2_upd) begin
                r_resp_data <= bram_data_out_a;
            end

            if (w_acc_u) begin
                r_last_r <= 1'b0;
            end else if (w_acc_r) begin
                r_last_r <= 1'b1;
            end
        end
    end

    assign busy           = r_s1_valid || r_s2_valid || r_s3_valid;
    assign bram_en_a      = r_s1_valid;
    assign bram_we_a      = 1'b0;
    assign bram_addr_a    = r_s1_addr;
    assign bram_data_in_a = '0;
    assign bram_en_b      = r_we_b;
    assign bram_we_b      = r_we_b;
    assign bram_addr_b    = r_addr_b;
    assign bram_data_in_b = r_data_b;
    assign rd_resp_valid  = r_resp_valid;
    assign rd_resp_data   = r_resp_data;

    // Port B read data has no consumer.
    assign w_unused_ok = ^bram_data_out_b;

endmodule
`default_nettype wire

// File: tb/tb_bram_rmw_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_rmw_scheduler
//  Description : Self-checking bench. Two DUTs (saturating and wrapping) share
//                one request stream, each with its own BRAM model. Accepted
//                ops push expected port-A, port-B and response events with
//                their due cycle; every cycle the due events are compared.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bram_rmw_scheduler;

    localparam int DW = 16;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          upd_valid = 1'b0, rd_valid = 1'b0, rd_clear = 1'b0;
    logic [AW-1:0] upd_addr = '0, rd_addr = '0;
    logic [DW-1:0] upd_delta = '0;
    logic [DW-1:0] zero_b = '0;

    logic          upd_ready_s, rd_ready_s, resp_v_s, busy_s, en_a_s, we_a_s, en_b_s, we_b_s;
    logic [AW-1:0] addr_a_s, addr_b_s;
    logic [DW-1:0] resp_d_s, din_a_s, din_b_s, dout_s;
    logic          upd_ready_w, rd_ready_w, resp_v_w, busy_w, en_a_w, we_a_w, en_b_w, we_b_w;
    logic [AW-1:0] addr_a_w, addr_b_w;
    logic [DW-1:0] resp_d_w, din_a_w, din_b_w, dout_w;

    bram_rmw_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_ready(upd_ready_s), .upd_addr(upd_addr), .upd_delta(upd_delta),
        .rd_valid(rd_valid), .rd_ready(rd_ready_s), .rd_addr(rd_addr), .rd_clear(rd_clear),
        .rd_resp_valid(resp_v_s), .rd_resp_data(resp_d_s), .busy(busy_s),
        .bram_en_a(en_a_s), .bram_we_a(we_a_s), .bram_addr_a(addr_a_s),
        .bram_data_in_a(din_a_s), .bram_data_out_a(dout_s),
        .bram_en_b(en_b_s), .bram_we_b(we_b_s), .bram_addr_b(addr_b_s),
        .bram_data_in_b(din_b_s), .bram_data_out_b(zero_b)
    );

    bram_rmw_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_ready(upd_ready_w), .upd_addr(upd_addr), .upd_delta(upd_delta),
        .rd_valid(rd_valid), .rd_ready(rd_ready_w), .rd_addr(rd_addr), .rd_clear(rd_clear),
        .rd_resp_valid(resp_v_w), .rd_resp_data(resp_d_w), .busy(busy_w),
        .bram_en_a(en_a_w), .bram_we_a(we_a_w), .bram_addr_a(addr_a_w),
        .bram_data_in_a(din_a_w), .bram_data_out_a(dout_w),
        .bram_en_b(en_b_w), .bram_we_b(we_b_w), .bram_addr_b(addr_b_w),
        .bram_data_in_b(din_b_w), .bram_data_out_b(zero_b)
    );

    // BRAM models, with a preload/clear side door used only while idle.
    logic [DW-1:0] mem_s [0:(1<<AW)-1];
    logic [DW-1:0] mem_w [0:(1<<AW)-1];
    logic          pl_en = 1'b0, pl_clr = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < (1<<AW); i++) begin
                mem_s[i] <= '0;
                mem_w[i] <= '0;
            end
        end else if (pl_en) begin
            mem_s[pl_addr] <= pl_data;
            mem_w[pl_addr] <= pl_data;
        end else begin
            if (en_b_s && we_b_s) mem_s[addr_b_s] <= din_b_s;
            if (en_b_w && we_b_w) mem_w[addr_b_w] <= din_b_w;
        end
        if (en_a_s) dout_s <= mem_s[addr_a_s];
        if (en_a_w) dout_w <= mem_w[addr_a_w];
    end

    // Scoreboard
    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] d;
        logic [DW-1:0] dw;
    } exp_t;

    exp_t          qa[$], qb[$], qr[$];
    logic [DW-1:0] ref_s [0:(1<<AW)-1];
    logic [DW-1:0] ref_w [0:(1<<AW)-1];
    int            nvec = 0, nerr = 0;
    int            cyc = 0, last_c = 0;
    logic          got_u = 1'b0, got_r = 1'b0, zero_chk = 1'b0;
    logic [2:0]    hist = '0;

    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] o, input logic [DW-1:0] dl);
        int s;
        s = int'($signed(o)) + int'($signed(dl));
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check due events at the negedge, log accepts, advance.
    task automatic step();
        logic e;
        logic [DW-1:0] o_s, o_w, n_s, n_w;
        @(negedge clk);
        last_c = cyc;
        e = (qa.size() > 0) && (qa[0].cyc == cyc);
        chk("en_a", en_a_s, e);
        chk("en_a_wrap", en_a_w, e);
        if (e) begin
            chk("addr_a", addr_a_s, qa[0].addr);
            void'(qa.pop_front());
        end
        e = (qb.size() > 0) && (qb[0].cyc == cyc);
        chk("we_b", we_b_s, e);
        chk("en_b", en_b_s, e);
        chk("we_b_wrap", we_b_w, e);
        if (e) begin
            chk("addr_b", addr_b_s, qb[0].addr);
            chk("data_b", din_b_s, qb[0].d);
            chk("data_b_wrap", din_b_w, qb[0].dw);
            void'(qb.pop_front());
        end
        e = (qr.size() > 0) && (qr[0].cyc == cyc);
        chk("resp_valid", resp_v_s, e);
        if (e) begin
            chk("resp_data", resp_d_s, qr[0].d);
            chk("resp_data_wrap", resp_d_w, qr[0].dw);
            void'(qr.pop_front());
        end
        chk("busy", busy_s, |hist);
        chk("we_a", we_a_s, 1'b0);
        chk("data_in_a", din_a_s, 16'h0);
        chk("one_grant", upd_ready_s & rd_ready_s, 1'b0);
        if (zero_chk) begin
            chk("z_upd_ready", upd_ready_s, 1'b0);
            chk("z_rd_ready", rd_ready_s, 1'b0);
            chk("z_addr_a", addr_a_s, 10'h0);
            chk("z_addr_b", addr_b_s, 10'h0);
            chk("z_data_b", din_b_s, 16'h0);
            chk("z_resp_data", resp_d_s, 16'h0);
        end
        got_u = upd_valid && upd_ready_s;
        got_r = rd_valid && rd_ready_s;
        if (got_u) begin
            o_s = ref_s[upd_addr];
            o_w = ref_w[upd_addr];
            n_s = sat_add(o_s, upd_delta);
            n_w = o_w + upd_delta;
            ref_s[upd_addr] = n_s;
            ref_w[upd_addr] = n_w;
            qa.push_back('{cyc + 1, upd_addr, 16'h0, 16'h0});
            qb.push_back('{cyc + 3, upd_addr, n_s, n_w});
        end
        if (got_r) begin
            qa.push_back('{cyc + 1, rd_addr, 16'h0, 16'h0});
            qr.push_back('{cyc + 3, rd_addr, ref_s[rd_addr], ref_w[rd_addr]});
            if (rd_clear) begin
                ref_s[rd_addr] = '0;
                ref_w[rd_addr] = '0;
                qb.push_back('{cyc + 3, rd_addr, 16'h0, 16'h0});
            end
        end
        hist = {hist[1:0], got_u | got_r};
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        step();
        pl_en = 1'b0;
        ref_s[a] = v;
        ref_w[a] = v;
    endtask

    task automatic issue_upd(input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc_c);
        upd_addr = a; upd_delta = d; upd_valid = 1'b1; acc_c = -1;
        for (int k = 0; k < 16 && acc_c < 0; k++) begin
            step();
            if (got_u) acc_c = last_c;
        end
        upd_valid = 1'b0;
        chk("upd_accepted", acc_c >= 0, 1'b1);
    endtask

    task automatic issue_rd(input logic [AW-1:0] a, input logic clr, output int acc_c);
        rd_addr = a; rd_clear = clr; rd_valid = 1'b1; acc_c = -1;
        for (int k = 0; k < 16 && acc_c < 0; k++) begin
            step();
            if (got_r) acc_c = last_c;
        end
        rd_valid = 1'b0;
        chk("rd_accepted", acc_c >= 0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int t1, t2, ui, ri, first_r;
        logic [AW-1:0] chk_addrs [0:14];

        for (int i = 0; i < (1<<AW); i++) begin
            ref_s[i] = '0;
            ref_w[i] = '0;
        end

        // Reset, with memories cleared; outputs must read 0 once reset is seen.
        pl_clr = 1'b1;
        step();
        pl_clr = 1'b0;
        zero_chk = 1'b1;
        idle(2);
        rst = 1'b0;
        step();
        zero_chk = 1'b0;

        // Basic update: 100 - 30 = 70, write 3 cycles after accept.
        preload(10'd5, 16'd100);
        issue_upd(10'd5, 16'hFFE2, t1);
        idle(5);

        // Same-address back-to-back updates stall 2 cycles.
        issue_upd(10'd7, 16'd1, t1);
        issue_upd(10'd7, 16'd1, t2);
        chk("same_addr_spacing", t2 - t1, 3);
        idle(5);

        // Overflow behaviour (saturating DUT clamps, wrapping DUT wraps).
        preload(10'd20, 16'd32760);
        preload(10'd21, 16'h8008);
        preload(10'd22, 16'd32767);
        issue_upd(10'd20, 16'd100, t1);
        issue_upd(10'd21, 16'hFF9C, t1);
        issue_upd(10'd22, 16'd1, t1);
        idle(5);

        // Clear-on-read, then a plain read of the cleared word.
        preload(10'd3, 16'd55);
        issue_rd(10'd3, 1'b1, t1);
        issue_rd(10'd3, 1'b0, t2);
        chk("clear_read_spacing", t2 - t1, 3);
        idle(5);

        // Both requesters busy: grants alternate starting with U (R served last).
        for (int i = 0; i < 4; i++) begin
            preload(AW'(100 + i), DW'(1000 + 7 * i));
            preload(AW'(200 + i), DW'(2000 + 11 * i));
        end
        ui = 0; ri = 0;
        upd_addr = AW'(100); upd_delta = DW'(3);
        rd_addr = AW'(200); rd_clear = 1'b0;
        upd_valid = 1'b1; rd_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("alt_grant_u", got_u, (k % 2) == 0);
            chk("alt_grant_r", got_r, (k % 2) == 1);
            if (got_u) begin
                ui++;
                upd_addr = AW'(100 + ui); upd_delta = DW'(3 + ui);
            end
            if (got_r) begin
                ri++;
                rd_addr = AW'(200 + ri);
            end
            if (ui == 4) upd_valid = 1'b0;
            if (ri == 4) rd_valid = 1'b0;
        end
        upd_valid = 1'b0; rd_valid = 1'b0;
        idle(5);

        // Reset in the S2 cycle of an update: the write is dropped.
        preload(10'd40, 16'd1234);
        preload(10'd41, 16'd4321);
        issue_upd(10'd40, 16'd5, t1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        qa.delete(); qb.delete(); qr.delete();
        hist = '0;
        ref_s[40] = 16'd1234;
        ref_w[40] = 16'd1234;
        zero_chk = 1'b1;
        step();
        zero_chk = 1'b0;
        idle(4);
        chk("rst_mem_unchanged", mem_s[40], 16'd1234);

        // After reset the pointer is U, so R wins the first contention.
        upd_addr = 10'd40; upd_delta = 16'd5; upd_valid = 1'b1;
        rd_addr = 10'd41; rd_clear = 1'b0; rd_valid = 1'b1;
        first_r = -1;
        for (int k = 0; k < 8 && (upd_valid || rd_valid); k++) begin
            step();
            if (first_r < 0 && (got_u || got_r)) first_r = got_r ? 1 : 0;
            if (got_u) upd_valid = 1'b0;
            if (got_r) rd_valid = 1'b0;
        end
        upd_valid = 1'b0; rd_valid = 1'b0;
        chk("post_rst_first_grant_r", first_r, 1);
        idle(6);

        chk("drain_qa", qa.size(), 0);
        chk("drain_qb", qb.size(), 0);
        chk("drain_qr", qr.size(), 0);

        chk_addrs = '{10'd5, 10'd7, 10'd20, 10'd21, 10'd22, 10'd3, 10'd100, 10'd101,
                      10'd102, 10'd103, 10'd200, 10'd201, 10'd40, 10'd41, 10'd0};
        for (int i = 0; i < 15; i++) begin
            chk("mem_sat", mem_s[chk_addrs[i]], ref_s[chk_addrs[i]]);
            chk("mem_wrap", mem_w[chk_addrs[i]], ref_w[chk_addrs[i]]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
